// File: rtl/z16_prog_loader_if.sv
// z16_prog_loader_if: byte-stream input and instruction-memory/CPU-control outputs of the program loader.
interface z16_prog_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic [15:0] imem_addr;
    logic [15:0] imem_wdata;
    logic        imem_wen;
    logic        cpu_rst;
    logic        done;
    logic        err;
    modport master (
        output rx_valid, rx_data,
        input  rx_ready, imem_addr, imem_wdata, imem_wen, cpu_rst, done, err
    );
    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, imem_addr, imem_wdata, imem_wen, cpu_rst, done, err
    );
endinterface

// File: rtl/z16_prog_loader.sv
// z16_prog_loader: parses a framed byte stream into instruction-memory writes and holds the CPU in reset until a valid frame lands.
module z16_prog_loader #(
    parameter int         MAX_WORDS = 256,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input logic              i_clk,
    input logic              i_rst,
    z16_prog_loader_if.slave bus
);
    localparam logic [2:0] SYNC    = 3'd0;
    localparam logic [2:0] LEN_LO  = 3'd1;
    localparam logic [2:0] LEN_HI  = 3'd2;
    localparam logic [2:0] DATA_LO = 3'd3;
    localparam logic [2:0] DATA_HI = 3'd4;
    localparam logic [2:0] CSUM    = 3'd5;
    localparam logic [2:0] DONE    = 3'd6;
    localparam logic [2:0] ERR     = 3'd7;
    localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

    logic [2:0]  state_q, state_d;
    logic [15:0] len_q, len_d, cnt_q, cnt_d, addr_q, addr_d, wdata_q, wdata_d;
    logic [7:0]  lo_q, lo_d, csum_q, csum_d;
    logic        ready_q, wen_q, wen_d, cpu_rst_q, cpu_rst_d, done_q, done_d, err_q, err_d;
    logic        acc;
    logic [7:0]  b;
    logic [15:0] new_len, cnt_inc;

    assign acc     = bus.rx_valid & ready_q;
    assign b       = bus.rx_data;
    assign new_len = {b, len_q[7:0]};
    assign cnt_inc = cnt_q + 16'd1;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        csum_d    = csum_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wen_d     = 1'b0;
        cpu_rst_d = cpu_rst_q;
        done_d    = done_q;
        err_d     = err_q;
        if (acc) begin
            case (state_q)
                SYNC, DONE, ERR: if (b == SYNC_BYTE) begin
                    state_d   = LEN_LO;
                    csum_d    = 8'd0;
                    cnt_d     = 16'd0;
                    cpu_rst_d = 1'b1;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                end
                LEN_LO: begin
                    len_d[7:0] = b;
                    state_d    = LEN_HI;
                end
                LEN_HI: begin
                    len_d[15:8] = b;
                    state_d     = (new_len > MAX_LEN) ? ERR : (new_len == 16'd0) ? CSUM : DATA_LO;
                    err_d       = new_len > MAX_LEN;
                end
                DATA_LO: begin
                    lo_d    = b;
                    csum_d  = csum_q + b;
                    state_d = DATA_HI;
                end
                DATA_HI: begin
                    csum_d  = csum_q + b;
                    wen_d   = 1'b1;
                    addr_d  = {cnt_q[14:0], 1'b0};
                    wdata_d = {b, lo_q};
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == len_q) ? CSUM : DATA_LO;
                end
                CSUM: begin
                    state_d   = (b == csum_q) ? DONE : ERR;
                    done_d    = b == csum_q;
                    err_d     = b != csum_q;
                    cpu_rst_d = b != csum_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= SYNC;
            len_q     <= 16'd0;
            lo_q      <= 8'd0;
            cnt_q     <= 16'd0;
            csum_q    <= 8'd0;
            addr_q    <= 16'd0;
            wdata_q   <= 16'd0;
            wen_q     <= 1'b0;
            ready_q   <= 1'b0;
            cpu_rst_q <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            lo_q      <= lo_d;
            cnt_q     <= cnt_d;
            csum_q    <= csum_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wen_q     <= wen_d;
            ready_q   <= 1'b1;
            cpu_rst_q <= cpu_rst_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign bus.rx_ready   = ready_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.imem_wen   = wen_q;
    assign bus.cpu_rst    = cpu_rst_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_z16_prog_loader.sv
// tb_z16_prog_loader: directed and randomized frames checked against a frame-level reference parser.
module tb_z16_prog_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;
    logic [7:0]  fr[$];
    logic [15:0] exp_w[$];
    logic [15:0] wa[$];
    logic [15:0] wd[$];
    bit exp_done, exp_err;

    z16_prog_loader_if bus ();
    z16_prog_loader dut (.i_clk(clk), .i_rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Every cycle with the strobe high is logged, so a stretched pulse shows up as an extra write.
    always @(negedge clk) if (bus.imem_wen) begin
        wa.push_back(bus.imem_addr);
        wd.push_back(bus.imem_wdata);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] v, input int gap);
        int n = 0;
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = v;
        while (!bus.rx_ready) begin
            if (++n > 100) begin
                $display("FAIL ready_timeout observed=0 expected=1");
                $fatal(1);
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1 bus.rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_all(input int gap);
        foreach (fr[i]) send_byte(fr[i], gap);
    endtask

    // Reference: skip to the sync marker, read length, collect words, sum data bytes mod 256.
    task automatic model();
        int p = 0;
        int len;
        int sum = 0;
        exp_w.delete();
        exp_done = 0;
        exp_err  = 0;
        while (p < fr.size() && fr[p] != 8'hA5) p++;
        len = int'(fr[p+1]) + 256 * int'(fr[p+2]);
        if (len > 256) begin
            exp_err = 1;
            return;
        end
        for (int i = 0; i < len; i++) begin
            sum += int'(fr[p+3+2*i]) + int'(fr[p+4+2*i]);
            exp_w.push_back({fr[p+4+2*i], fr[p+3+2*i]});
        end
        exp_done = int'(fr[p+3+2*len]) == (sum % 256);
        exp_err  = !exp_done;
    endtask

    task automatic build_frame(input int n, input bit bad);
        int sum = 0;
        logic [15:0] w;
        fr = {8'hA5, 8'(n), 8'(n >> 8)};
        for (int i = 0; i < n; i++) begin
            w = 16'($urandom);
            fr.push_back(w[7:0]);
            fr.push_back(w[15:8]);
            sum += int'(w[7:0]) + int'(w[15:8]);
        end
        fr.push_back(8'(sum + (bad ? int'($urandom_range(1, 255)) : 0)));
    endtask

    task automatic check_frame(input string tag);
        repeat (2) @(negedge clk);
        model();
        chk({tag, "_nwrites"}, 32'(wa.size()), 32'(exp_w.size()));
        foreach (exp_w[i]) if (i < wa.size()) begin
            chk({tag, "_addr"}, 32'(wa[i]), 32'(2 * i));
            chk({tag, "_data"}, 32'(wd[i]), 32'(exp_w[i]));
        end
        chk({tag, "_done"}, 32'(bus.done), 32'(exp_done));
        chk({tag, "_err"}, 32'(bus.err), 32'(exp_err));
        chk({tag, "_cpu_rst"}, 32'(bus.cpu_rst), 32'(!exp_done));
        wa.delete();
        wd.delete();
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.rx_ready), 0);
        chk("rst_addr", 32'(bus.imem_addr), 0);
        chk("rst_wdata", 32'(bus.imem_wdata), 0);
        chk("rst_wen", 32'(bus.imem_wen), 0);
        chk("rst_cpu_rst", 32'(bus.cpu_rst), 1);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_err", 32'(bus.err), 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1 chk("ready_after_rst", 32'(bus.rx_ready), 1);

        // Test 1: two-word frame, back-to-back bytes, cycle-exact write and release.
        fr = {8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h14};
        for (int i = 0; i < 7; i++) begin
            send_byte(fr[i], 0);
            if (i == 4) begin
                chk("t1_wen_latency", 32'(bus.imem_wen), 1);
                chk("t1_wdata0", 32'(bus.imem_wdata), 32'h1234);
            end
        end
        chk("t1_cpu_rst_before", 32'(bus.cpu_rst), 1);
        send_byte(fr[7], 0);
        chk("t1_cpu_rst_fall", 32'(bus.cpu_rst), 0);
        chk("t1_done_edge", 32'(bus.done), 1);
        check_frame("t1");

        // Test 2: checksum off by one.
        fr = {8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h15};
        send_all(0);
        check_frame("t2");

        // Test 3: oversize length rejected, then an empty frame.
        fr = {8'hA5, 8'h01, 8'h01};
        send_all(0);
        check_frame("t3a");
        fr = {8'hA5, 8'h00, 8'h00, 8'h00};
        send_all(0);
        check_frame("t3b");

        // Test 4: leading garbage and idle gaps.
        fr = {8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h14};
        send_all(3);
        check_frame("t4");

        // Test 5: restart from DONE.
        send_byte(8'hA5, 0);
        chk("t5_cpu_rst", 32'(bus.cpu_rst), 1);
        chk("t5_done", 32'(bus.done), 0);
        fr = {8'hA5, 8'h01, 8'h00, 8'hCD, 8'hAB, 8'h78};
        for (int i = 1; i < 6; i++) send_byte(fr[i], 0);
        check_frame("t5");

        // Test 6: reset after three data bytes; bytes offered during reset must be ignored.
        fr = {8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h14};
        for (int i = 0; i < 6; i++) send_byte(fr[i], 0);
        @(negedge clk);
        rst = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hA5;
        repeat (2) @(posedge clk);
        #1;
        chk("t6_ready", 32'(bus.rx_ready), 0);
        chk("t6_cpu_rst", 32'(bus.cpu_rst), 1);
        chk("t6_done", 32'(bus.done), 0);
        chk("t6_nwrites", 32'(wa.size()), 1);
        if (wd.size() > 0) chk("t6_word0", 32'(wd[0]), 32'h1234);
        @(negedge clk);
        rst = 1'b0;
        bus.rx_valid = 1'b0;
        wa.delete();
        wd.delete();
        send_all(0);
        check_frame("t6");

        // Randomized frames, including the exact capacity limit and an oversize length.
        for (int r = 0; r < 8; r++) begin
            build_frame($urandom_range(0, 6), $urandom_range(0, 2) == 0);
            send_all($urandom_range(0, 2));
            check_frame("rnd");
        end
        build_frame(256, 0);
        send_all(0);
        check_frame("max_len");
        begin
            int n = $urandom_range(257, 65535);
            fr = {8'hA5, 8'(n), 8'(n >> 8)};
        end
        send_all(1);
        check_frame("over_len");
        build_frame(3, 0);
        send_all(0);
        check_frame("recover");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
